// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared constants, FSM encoding and field helpers for the instruction cache
package icache_pkg;

    localparam int ADDR_W         = 16;
    localparam int DATA_W         = 16;
    localparam int WORDS_PER_LINE = 4;
    localparam int OFFSET_BITS    = 2;
    localparam int OFFSET_LSB     = 1;
    localparam int INDEX_LSB      = OFFSET_LSB + OFFSET_BITS;
    localparam int DEF_INDEX_BITS = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Tag occupies everything above the index field.
    function automatic int tag_bits(input int index_bits);
        return ADDR_W - INDEX_LSB - index_bits;
    endfunction

    function automatic int tag_lsb(input int index_bits);
        return INDEX_LSB + index_bits;
    endfunction

endpackage

// File: rtl/icache_if.sv
// rtl/icache_if.sv - requester and backing-memory signal bundle of the cache
interface icache_if;
    import icache_pkg::*;

    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] DataIn;
    logic              Rd;
    logic              Wr;
    logic              createdump;
    logic [DATA_W-1:0] DataOut;
    logic              Done;
    logic              Stall;
    logic              CacheHit;
    logic              err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    // master: the requester side plus the backing memory responder
    modport master (
        output Addr, DataIn, Rd, Wr, createdump,
        input  DataOut, Done, Stall, CacheHit, err,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

    // slave: the cache controller
    modport slave (
        input  Addr, DataIn, Rd, Wr, createdump,
        output DataOut, Done, Stall, CacheHit, err,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

endinterface

// File: rtl/icache_array.sv
// rtl/icache_array.sv - valid, tag and data storage for the direct-mapped cache
module icache_array
    import icache_pkg::*;
#(
    parameter int  INDEX_BITS = DEF_INDEX_BITS,
    localparam int TAG_W      = tag_bits(INDEX_BITS),
    localparam int LINES      = 1 << INDEX_BITS
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [INDEX_BITS-1:0] rd_index_i,
    input  logic [OFFSET_BITS-1:0] rd_offset_i,
    output logic                  rd_valid_o,
    output logic [TAG_W-1:0]      rd_tag_o,
    output logic [DATA_W-1:0]     rd_data_o,
    input  logic                  wr_en_i,
    input  logic [INDEX_BITS-1:0] wr_index_i,
    input  logic [OFFSET_BITS-1:0] wr_offset_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic [INDEX_BITS-1:0] meta_index_i,
    input  logic                  tag_we_i,
    input  logic [TAG_W-1:0]      tag_i,
    input  logic                  valid_set_i,
    input  logic                  valid_clr_i
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES*WORDS_PER_LINE];

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[{rd_index_i, rd_offset_i}];

    // Valid bits: cleared by reset, cleared at miss entry, set when a fill completes.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (valid_set_i) begin
            valid_q[meta_index_i] <= 1'b1;
        end else if (valid_clr_i) begin
            valid_q[meta_index_i] <= 1'b0;
        end
    end

    // Tag storage, not reset; only meaningful under a set valid bit.
    always_ff @(posedge clk_i) begin
        if (tag_we_i) begin
            tag_q[meta_index_i] <= tag_i;
        end
    end

    // Word storage, not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            data_q[{wr_index_i, wr_offset_i}] <= wr_data_i;
        end
    end

endmodule

// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped write-through cache controller with backing req/ack port
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS
) (
    input logic   clk,
    input logic   rst,
    icache_if.slave bus
);

    localparam int TAG_W   = tag_bits(INDEX_BITS);
    localparam int TAG_LSB = tag_lsb(INDEX_BITS);

    state_e                  state_q;
    logic [OFFSET_BITS-1:0]  fill_cnt_q;
    logic [ADDR_W-1:1]       addr_q;
    logic                    hit_q;
    logic                    mem_req_q;
    logic                    mem_we_q;
    logic [ADDR_W-1:0]       mem_addr_q;
    logic [DATA_W-1:0]       mem_wdata_q;

    logic                    req_any, req_bad, req_rd, req_wr;
    logic [INDEX_BITS-1:0]   req_index, cur_index, lat_index;
    logic [OFFSET_BITS-1:0]  req_offset, cur_offset;
    logic [TAG_W-1:0]        req_tag;
    logic                    idle, hit, ack, fill_last;

    logic                    arr_valid;
    logic [TAG_W-1:0]        arr_tag;
    logic [DATA_W-1:0]       arr_data;
    logic                    wr_en, tag_we, valid_set, valid_clr;
    logic [INDEX_BITS-1:0]   wr_index, meta_index;
    logic [OFFSET_BITS-1:0]  wr_offset;
    logic [DATA_W-1:0]       wr_data;

    wire unused_createdump = bus.createdump;

    assign req_any    = bus.Rd | bus.Wr;
    assign req_bad    = (bus.Rd & bus.Wr) | (req_any & bus.Addr[0]);
    assign req_rd     = bus.Rd & ~bus.Wr & ~bus.Addr[0];
    assign req_wr     = bus.Wr & ~bus.Rd & ~bus.Addr[0];
    assign req_index  = bus.Addr[INDEX_LSB +: INDEX_BITS];
    assign req_offset = bus.Addr[OFFSET_LSB +: OFFSET_BITS];
    assign req_tag    = bus.Addr[TAG_LSB +: TAG_W];
    assign lat_index  = addr_q[INDEX_LSB +: INDEX_BITS];

    // The read port follows the live address in IDLE so hits answer in the request cycle;
    // elsewhere it looks at the latched request for the DONE data word.
    assign idle       = (state_q == S_IDLE);
    assign cur_index  = idle ? req_index  : lat_index;
    assign cur_offset = idle ? req_offset : addr_q[OFFSET_LSB +: OFFSET_BITS];
    assign hit        = arr_valid && (arr_tag == req_tag);
    assign ack        = bus.mem_ack & mem_req_q;
    assign fill_last  = (fill_cnt_q == 2'd3);

    icache_array #(.INDEX_BITS(INDEX_BITS)) u_array (
        .clk_i        (clk),
        .rst_ni       (rst),
        .rd_index_i   (cur_index),
        .rd_offset_i  (cur_offset),
        .rd_valid_o   (arr_valid),
        .rd_tag_o     (arr_tag),
        .rd_data_o    (arr_data),
        .wr_en_i      (wr_en),
        .wr_index_i   (wr_index),
        .wr_offset_i  (wr_offset),
        .wr_data_i    (wr_data),
        .meta_index_i (meta_index),
        .tag_we_i     (tag_we),
        .tag_i        (req_tag),
        .valid_set_i  (valid_set),
        .valid_clr_i  (valid_clr)
    );

    // Array update controls: miss entry claims the line, write hits update in place, fill acks store words.
    always_comb begin
        wr_en      = 1'b0;
        wr_index   = req_index;
        wr_offset  = req_offset;
        wr_data    = bus.DataIn;
        meta_index = req_index;
        tag_we     = 1'b0;
        valid_set  = 1'b0;
        valid_clr  = 1'b0;
        if (rst) begin
            case (state_q)
                S_IDLE: begin
                    if (req_rd && !hit) begin
                        tag_we    = 1'b1;
                        valid_clr = 1'b1;
                    end
                    if (req_wr && hit) begin
                        wr_en = 1'b1;
                    end
                end
                S_FILL: begin
                    if (ack) begin
                        wr_en      = 1'b1;
                        wr_index   = lat_index;
                        wr_offset  = fill_cnt_q;
                        wr_data    = bus.mem_rdata;
                        meta_index = lat_index;
                        valid_set  = fill_last;
                    end
                end
                default: ;
            endcase
        end
    end

    // Requester responses; hits and errors complete combinationally in IDLE.
    always_comb begin
        bus.Done     = 1'b0;
        bus.Stall    = 1'b0;
        bus.CacheHit = 1'b0;
        bus.err      = 1'b0;
        bus.DataOut  = '0;
        if (rst) begin
            case (state_q)
                S_IDLE: begin
                    if (req_bad) begin
                        bus.Done = 1'b1;
                        bus.err  = 1'b1;
                    end else if (req_rd && hit) begin
                        bus.Done     = 1'b1;
                        bus.CacheHit = 1'b1;
                        bus.DataOut  = arr_data;
                    end else if (req_any) begin
                        bus.Stall = 1'b1;
                    end
                end
                S_FILL, S_WRITE: bus.Stall = 1'b1;
                S_DONE: begin
                    bus.Done     = 1'b1;
                    bus.CacheHit = hit_q;
                    bus.DataOut  = arr_data;
                end
                default: ;
            endcase
        end
    end

    // Controller FSM with request latches, fill counter and registered backing port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            fill_cnt_q  <= '0;
            addr_q      <= '0;
            hit_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_rd && !hit) begin
                        addr_q     <= bus.Addr[ADDR_W-1:1];
                        hit_q      <= 1'b0;
                        fill_cnt_q <= '0;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= {bus.Addr[ADDR_W-1:INDEX_LSB], 3'b000};
                        state_q    <= S_FILL;
                    end else if (req_wr) begin
                        addr_q      <= bus.Addr[ADDR_W-1:1];
                        hit_q       <= hit;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {bus.Addr[ADDR_W-1:1], 1'b0};
                        mem_wdata_q <= bus.DataIn;
                        state_q     <= S_WRITE;
                    end
                end
                S_FILL: begin
                    if (ack) begin
                        if (fill_last) begin
                            mem_req_q <= 1'b0;
                            state_q   <= S_DONE;
                        end else begin
                            fill_cnt_q <= fill_cnt_q + 2'd1;
                            mem_addr_q <= {addr_q[ADDR_W-1:INDEX_LSB], fill_cnt_q + 2'd1, 1'b0};
                        end
                    end
                end
                S_WRITE: begin
                    if (ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - self-checking bench for icache_ctrl with backing memory responder
module tb_icache_ctrl;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } op_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    icache_if bus ();

    icache_ctrl #(.INDEX_BITS(4)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mem_m [logic [15:0]];
    op_t         ops_q[$];
    op_t         exp_ops[$];
    int          lat_max = 0;
    int          ack_cnt = 0;

    logic        m_valid [16];
    logic [8:0]  m_tag   [16];
    logic        exp_err, exp_hit, exp_rd;
    logic [15:0] exp_data;
    bit          cmp_en = 0;
    bit          req_active = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return {~a[7:0], a[7:0]};
    endfunction

    // Backing memory: one ack per request after a random 0..lat_max cycle wait.
    initial begin : responder
        bit          busy;
        int          wait_left;
        logic [15:0] a_seen, d_seen;
        logic        we_seen;
        busy = 0; wait_left = 0; a_seen = '0; d_seen = '0; we_seen = 1'b0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (!rst_n) begin
                busy = 0;
            end else if (bus.mem_req) begin
                if (!busy) begin
                    busy = 1;
                    wait_left = $urandom_range(lat_max, 0);
                    a_seen = bus.mem_addr;
                    we_seen = bus.mem_we;
                    d_seen = bus.mem_wdata;
                    chk("mem_addr_bit0", bus.mem_addr[0], 1'b0);
                end else begin
                    chk("mem_addr_stable", bus.mem_addr, a_seen);
                    chk("mem_we_stable", bus.mem_we, we_seen);
                    if (we_seen) chk("mem_wdata_stable", bus.mem_wdata, d_seen);
                end
                if (wait_left == 0) begin
                    bus.mem_ack = 1'b1;
                    busy = 0;
                    ack_cnt++;
                    if (we_seen) mem_m[a_seen] = d_seen;
                    else bus.mem_rdata = mem_val(a_seen);
                    ops_q.push_back('{we: we_seen, addr: a_seen, data: d_seen});
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // Per-cycle comparison of requester outputs against the request-level model.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (cmp_en && rst_n) begin
                if (req_active) begin
                    if (bus.Done) begin
                        chk("err", bus.err, exp_err);
                        chk("cache_hit", bus.CacheHit, exp_err ? 1'b0 : exp_hit);
                        chk("stall_at_done", bus.Stall, 1'b0);
                        if (exp_rd && !exp_err) chk("data_out", bus.DataOut, exp_data);
                        if (exp_err) chk("err_no_mem_req", bus.mem_req, 1'b0);
                    end else begin
                        chk("stall_busy", bus.Stall, 1'b1);
                    end
                end else begin
                    chk("idle_done", bus.Done, 1'b0);
                    chk("idle_stall", bus.Stall, 1'b0);
                    chk("idle_mem_req", bus.mem_req, 1'b0);
                end
            end
        end
    end

    task automatic do_req(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                          output int cycles, output logic [15:0] dout, output logic hit, output logic er);
        int         idx;
        logic [8:0] tg;
        idx = int'(a[6:3]);
        tg = a[15:7];
        exp_ops.delete();
        ops_q.delete();
        exp_rd = rd && !wr;
        exp_err = (rd && wr) || ((rd || wr) && a[0]);
        exp_hit = 1'b0;
        exp_data = mem_val(a);
        if (!exp_err) begin
            exp_hit = m_valid[idx] && (m_tag[idx] == tg);
            if (rd && !exp_hit) begin
                for (int k = 0; k < 4; k++)
                    exp_ops.push_back('{we: 1'b0, addr: {a[15:3], 2'(k), 1'b0}, data: 16'h0});
                m_valid[idx] = 1'b1;
                m_tag[idx] = tg;
            end
            if (wr) exp_ops.push_back('{we: 1'b1, addr: a, data: d});
        end
        @(posedge clk); #1;
        bus.Addr = a; bus.DataIn = d; bus.Rd = rd; bus.Wr = wr;
        req_active = 1;
        cycles = 0; dout = '0; hit = 1'b0; er = 1'b0;
        while (cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (bus.Done) begin
                dout = bus.DataOut; hit = bus.CacheHit; er = bus.err;
                break;
            end
        end
        if (cycles >= 200) chk("done_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        bus.Rd = 1'b0; bus.Wr = 1'b0;
        req_active = 0;
        chk("ops_count", ops_q.size(), exp_ops.size());
        for (int i = 0; i < ops_q.size() && i < exp_ops.size(); i++) begin
            chk("op_we", ops_q[i].we, exp_ops[i].we);
            chk("op_addr", ops_q[i].addr, exp_ops[i].addr);
            if (exp_ops[i].we) chk("op_data", ops_q[i].data, exp_ops[i].data);
        end
    endtask

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [15:0] a;
        logic [15:0] d;
    } vec_t;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          cyc, n;
        logic [15:0] dout;
        logic        hit, er;
        vec_t        rvec [8];

        bus.Addr = '0; bus.DataIn = '0; bus.Rd = 1'b0; bus.Wr = 1'b0; bus.createdump = 1'b0;
        for (int i = 0; i < 16; i++) begin m_valid[i] = 1'b0; m_tag[i] = '0; end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_done", bus.Done, 1'b0);
        chk("rst_stall", bus.Stall, 1'b0);
        chk("rst_hit", bus.CacheHit, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_dout", bus.DataOut, 16'h0);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 16'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 16'h0);
        cmp_en = 1;

        // cold miss then hit in the same line
        do_req(1, 0, 16'h0010, 0, cyc, dout, hit, er);
        chk("t1_cycles", cyc, 6); chk("t1_hit", hit, 0); chk("t1_dout", dout, 16'hEF10);
        chk("t1_op0", ops_q[0].addr, 16'h0010); chk("t1_op3", ops_q[3].addr, 16'h0016);
        do_req(1, 0, 16'h0014, 0, cyc, dout, hit, er);
        chk("t2_cycles", cyc, 1); chk("t2_hit", hit, 1); chk("t2_dout", dout, 16'hEB14);

        // conflict on index 2
        do_req(1, 0, 16'h0090, 0, cyc, dout, hit, er);
        chk("t3_hit", hit, 0); chk("t3_cycles", cyc, 6); chk("t3_dout", dout, 16'h6F90);
        do_req(1, 0, 16'h0010, 0, cyc, dout, hit, er);
        chk("t3b_hit", hit, 0); chk("t3b_cycles", cyc, 6);

        // write hit, write miss
        do_req(0, 1, 16'h0012, 16'hBEEF, cyc, dout, hit, er);
        chk("t4_cycles", cyc, 3); chk("t4_hit", hit, 1); chk("t4_op", ops_q[0].addr, 16'h0012);
        do_req(1, 0, 16'h0012, 0, cyc, dout, hit, er);
        chk("t4b_cycles", cyc, 1); chk("t4b_hit", hit, 1); chk("t4b_dout", dout, 16'hBEEF);
        do_req(0, 1, 16'h0100, 16'h1234, cyc, dout, hit, er);
        chk("t5_hit", hit, 0); chk("t5_cycles", cyc, 3);
        do_req(1, 0, 16'h0100, 0, cyc, dout, hit, er);
        chk("t5b_hit", hit, 0); chk("t5b_cycles", cyc, 6); chk("t5b_dout", dout, 16'h1234);

        // illegal requests
        do_req(1, 0, 16'h0011, 0, cyc, dout, hit, er);
        chk("t6_err", er, 1); chk("t6_cycles", cyc, 1); chk("t6_hit", hit, 0);
        do_req(1, 1, 16'h0010, 16'h7777, cyc, dout, hit, er);
        chk("t6b_err", er, 1); chk("t6b_cycles", cyc, 1);
        do_req(0, 1, 16'h0013, 16'h7777, cyc, dout, hit, er);
        chk("t6c_err", er, 1);

        // reset one cycle after the second fill ack
        cmp_en = 0;
        ack_cnt = 0;
        @(posedge clk); #1;
        bus.Addr = 16'h0020; bus.Rd = 1'b1;
        n = 0;
        while (ack_cnt < 2 && n < 50) begin @(negedge clk); #1; n++; end
        chk("t7_two_acks", ack_cnt, 2);
        @(posedge clk); #1;
        rst_n = 1'b0; bus.Rd = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t7_mem_req_off", bus.mem_req, 1'b0);
        chk("t7_stall_off", bus.Stall, 1'b0);
        chk("t7_done_off", bus.Done, 1'b0);
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        cmp_en = 1;
        do_req(1, 0, 16'h0020, 0, cyc, dout, hit, er);
        chk("t7b_hit", hit, 0); chk("t7b_cycles", cyc, 6); chk("t7b_ops", ops_q.size(), 4);

        // random backing latency
        lat_max = 5;
        rvec[0] = '{rd: 1, wr: 0, a: 16'h0200, d: 16'h0};
        rvec[1] = '{rd: 1, wr: 0, a: 16'h0202, d: 16'h0};
        rvec[2] = '{rd: 0, wr: 1, a: 16'h0204, d: 16'h5555};
        rvec[3] = '{rd: 1, wr: 0, a: 16'h0204, d: 16'h0};
        rvec[4] = '{rd: 1, wr: 0, a: 16'h0A00, d: 16'h0};
        rvec[5] = '{rd: 1, wr: 0, a: 16'h0200, d: 16'h0};
        rvec[6] = '{rd: 0, wr: 1, a: 16'h0300, d: 16'hA1B2};
        rvec[7] = '{rd: 1, wr: 0, a: 16'h0306, d: 16'h0};
        for (int i = 0; i < 8; i++) begin
            do_req(rvec[i].rd, rvec[i].wr, rvec[i].a, rvec[i].d, cyc, dout, hit, er);
        end
        chk("t8_hit_after_write", hit, 0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
